// File: rtl/arb_bus_mux.sv
// arb_bus_mux: moves the granted master's burst onto one shared valid/ready bus,
// signals per-master beat/completion strobes and flags grant-protocol violations.
module arb_bus_mux #(
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          gnt0,
    input  logic          gnt1,
    input  logic          gnt2,
    input  logic          gnt3,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic [LW-1:0] len2,
    input  logic [LW-1:0] len3,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    input  logic [DW-1:0] data2,
    input  logic [DW-1:0] data3,
    input  logic          bus_ready,
    output logic          bus_valid,
    output logic [DW-1:0] bus_data,
    output logic [1:0]    bus_src,
    output logic          bus_last,
    output logic          take0,
    output logic          take1,
    output logic          take2,
    output logic          take3,
    output logic          done0,
    output logic          done1,
    output logic          done2,
    output logic          done3,
    output logic          abort,
    output logic          gnt_err
);
    typedef enum logic [1:0] {IDLE, XFER, DONE, WAIT_REL} state_t;
    state_t            state, state_nx;
    logic [1:0]        src, src_nx;
    logic [LW-1:0]     len_q, len_nx, cnt, cnt_nx;
    logic              abort_nx;
    logic [3:0]        gnt, take, done;
    logic [3:0][LW-1:0] len_v;
    logic [3:0][DW-1:0] data_v;
    logic [2:0]        gnt_cnt;
    logic [1:0]        gnt_idx;
    assign gnt     = {gnt3, gnt2, gnt1, gnt0};
    assign len_v   = {len3, len2, len1, len0};
    assign data_v  = {data3, data2, data1, data0};
    assign gnt_cnt = 3'(gnt0) + 3'(gnt1) + 3'(gnt2) + 3'(gnt3);
    // only meaningful when exactly one grant is high
    assign gnt_idx = {gnt[3] | gnt[2], gnt[3] | gnt[1]};
    assign bus_valid = state == XFER;
    assign bus_last  = bus_valid && cnt == len_q;
    assign bus_src   = src;
    assign bus_data  = data_v[src];
    // a beat offered while the grant is already gone is not accepted
    assign take = (bus_valid && bus_ready && gnt[src]) ? 4'b0001 << src : 4'b0000;
    assign done = (state == DONE) ? 4'b0001 << src : 4'b0000;
    assign {take3, take2, take1, take0} = take;
    assign {done3, done2, done1, done0} = done;
    always_comb begin
        state_nx = state;
        src_nx   = src;
        len_nx   = len_q;
        cnt_nx   = cnt;
        abort_nx = 1'b0;
        case (state)
            IDLE: if (gnt_cnt == 3'd1) begin
                state_nx = XFER;
                src_nx   = gnt_idx;
                len_nx   = len_v[gnt_idx];
                cnt_nx   = '0;
            end
            XFER: if (!gnt[src]) begin
                state_nx = IDLE;
                abort_nx = 1'b1;
            end else if (bus_ready) begin
                state_nx = bus_last ? DONE : XFER;
                cnt_nx   = bus_last ? cnt : cnt + 1'b1;
            end
            DONE:     state_nx = WAIT_REL;
            WAIT_REL: state_nx = gnt[src] ? WAIT_REL : IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            src     <= '0;
            len_q   <= '0;
            cnt     <= '0;
            abort   <= 1'b0;
            gnt_err <= 1'b0;
        end else begin
            state   <= state_nx;
            src     <= src_nx;
            len_q   <= len_nx;
            cnt     <= cnt_nx;
            abort   <= abort_nx;
            gnt_err <= gnt_err | (gnt_cnt > 3'd1);
        end
    end
endmodule

// File: tb/tb_arb_bus_mux.sv
// tb_arb_bus_mux: directed bench with a beats-remaining reference model checked every cycle.
module tb_arb_bus_mux;
    localparam int DW = 8;
    localparam int LW = 4;
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    gnt = 4'b0;
    logic [LW-1:0] len [4];
    logic [DW-1:0] data [4];
    logic          bus_ready = 1'b0;
    logic          bus_valid, bus_last, abort, gnt_err;
    logic [DW-1:0] bus_data;
    logic [1:0]    bus_src;
    logic          take0, take1, take2, take3, done0, done1, done2, done3;
    wire  [3:0]    take = {take3, take2, take1, take0};
    wire  [3:0]    done = {done3, done2, done1, done0};
    int total = 0;
    int bad = 0;
    int n_take [4] = '{0, 0, 0, 0};
    int n_done [4] = '{0, 0, 0, 0};
    int n_abort = 0;
    bit m_arm = 0, m_act = 0, m_done = 0, m_hold = 0, m_abort = 0, m_err = 0;
    int m_src = 0;
    int m_left = 0;

    arb_bus_mux #(.DW(DW), .LW(LW)) dut (
        .clock(clock), .reset(reset),
        .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
        .len0(len[0]), .len1(len[1]), .len2(len[2]), .len3(len[3]),
        .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
        .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
        .bus_src(bus_src), .bus_last(bus_last),
        .take0(take0), .take1(take1), .take2(take2), .take3(take3),
        .done0(done0), .done1(done1), .done2(done2), .done3(done3),
        .abort(abort), .gnt_err(gnt_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    // reference: a burst is "beats remaining"; a finished burst owes one done
    // cycle, then a hold until its grant falls
    always @(posedge clock) begin
        if (!reset) begin
            m_arm <= 1; m_act <= 0; m_done <= 0; m_hold <= 0;
            m_abort <= 0; m_err <= 0; m_src <= 0; m_left <= 0;
        end else begin
            m_err   <= m_err | ($countones(gnt) >= 2);
            m_abort <= 0;
            if (m_act) begin
                if (!gnt[m_src]) begin
                    m_act <= 0; m_abort <= 1;
                end else if (bus_ready) begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin m_act <= 0; m_done <= 1; end
                end
            end else if (m_done) begin
                m_done <= 0; m_hold <= 1;
            end else if (m_hold) begin
                if (!gnt[m_src]) m_hold <= 0;
            end else if ($countones(gnt) == 1) begin
                m_src  <= idx(gnt);
                m_left <= int'(len[idx(gnt)]) + 1;
                m_act  <= 1;
            end
        end
    end

    always @(negedge clock) begin
        if (m_arm) begin
            chk("valid", int'(bus_valid), int'(m_act));
            chk("last", int'(bus_last), int'(m_act && m_left == 1));
            chk("take", int'(take), (m_act && bus_ready && gnt[m_src]) ? (1 << m_src) : 0);
            chk("done", int'(done), m_done ? (1 << m_src) : 0);
            chk("abort", int'(abort), int'(m_abort));
            chk("gnt_err", int'(gnt_err), int'(m_err));
            chk("src", int'(bus_src), m_src);
            chk("data", int'(bus_data), int'(data[m_src]));
            for (int i = 0; i < 4; i++) begin
                n_take[i] <= n_take[i] + int'(take[i]);
                n_done[i] <= n_done[i] + int'(done[i]);
            end
            n_abort <= n_abort + int'(abort);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int t0, d0, a0;
        for (int i = 0; i < 4; i++) begin len[i] = '0; data[i] = DW'(8'h40 + i); end
        step(); step();
        reset = 1'b1;
        // reset during an active burst
        gnt = 4'b0010; len[1] = 4'd3; bus_ready = 1'b0;
        step(); step();
        #1 chk("rst_pre_valid", int'(bus_valid), 1);
        reset = 1'b0;
        step(); step();
        chk("rst_valid", int'(bus_valid), 0);
        chk("rst_take_done", int'({take, done}), 0);
        chk("rst_abort_err", int'({abort, gnt_err}), 0);
        chk("rst_src", int'(bus_src), 0);
        gnt = 4'b0; reset = 1'b1;
        step(); step();
        chk("rst_rel_valid", int'(bus_valid), 0);
        // single burst, 4 beats, ready held high
        gnt = 4'b0010; len[1] = 4'd3; bus_ready = 1'b1; data[1] = 8'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            data[1] = DW'(8'h10 + i);
            #1;
            chk("sb_data", int'(bus_data), 8'h10 + i);
            chk("sb_last", int'(bus_last), int'(i == 3));
            chk("sb_take1", int'(take1), 1);
            chk("sb_src", int'(bus_src), 1);
        end
        step();
        chk("sb_done1", int'(done1), 1);
        chk("sb_valid_off", int'(bus_valid), 0);
        gnt = 4'b0;
        step(); step();
        chk("sb_done_cnt", n_done[1], 1);
        chk("sb_take_cnt", n_take[1], 4);
        // backpressure on a 2-beat burst
        t0 = n_take[2]; d0 = n_done[2];
        gnt = 4'b0100; len[2] = 4'd1; data[2] = 8'h20; bus_ready = 1'b0;
        step();
        #1 chk("bp_hold_take", int'(take2), 0);
        bus_ready = 1'b1;
        #1 chk("bp_take_a", int'(take2), 1);
        chk("bp_last_a", int'(bus_last), 0);
        step();
        data[2] = 8'h21; bus_ready = 1'b0;
        #1 chk("bp_data_b", int'(bus_data), 8'h21);
        chk("bp_last_b", int'(bus_last), 1);
        step();
        bus_ready = 1'b1;
        step();
        chk("bp_done2", int'(done2), 1);
        gnt = 4'b0;
        step(); step();
        chk("bp_take_cnt", n_take[2] - t0, 2);
        chk("bp_done_cnt", n_done[2] - d0, 1);
        // grant lost after 3 accepted beats
        a0 = n_abort; d0 = n_done[0];
        gnt = 4'b0001; len[0] = 4'd7; data[0] = 8'h30;
        step(); step(); step(); step();
        gnt = 4'b0;
        #1 chk("gl_take_blocked", int'(take0), 0);
        chk("gl_valid_still", int'(bus_valid), 1);
        step();
        chk("gl_abort", int'(abort), 1);
        chk("gl_valid_off", int'(bus_valid), 0);
        step(); step();
        chk("gl_abort_cnt", n_abort - a0, 1);
        chk("gl_no_done", n_done[0] - d0, 0);
        // release wait: grant held after done blocks a re-serve
        gnt = 4'b1000; len[3] = 4'd0; data[3] = 8'h55;
        step();
        chk("rw_last", int'(bus_last), 1);
        step();
        chk("rw_done3", int'(done3), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_hold_valid", int'(bus_valid), 0);
        end
        gnt = 4'b0001; len[0] = 4'd0;
        step();
        chk("rw_idle_valid", int'(bus_valid), 0);
        step();
        chk("rw_new_valid", int'(bus_valid), 1);
        chk("rw_new_src", int'(bus_src), 0);
        step();
        gnt = 4'b0;
        step(); step();
        // two grants at once in IDLE
        gnt = 4'b0101;
        step();
        chk("pe_err", int'(gnt_err), 1);
        chk("pe_no_burst", int'(bus_valid), 0);
        step();
        chk("pe_no_burst2", int'(bus_valid), 0);
        gnt = 4'b0;
        step(); step();
        chk("pe_sticky", int'(gnt_err), 1);
        reset = 1'b0;
        step();
        chk("pe_cleared", int'(gnt_err), 0);
        reset = 1'b1;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
